fir_host_seq: RTL
=================

Name: fir_host_seq

Overview:
Host-side sequencer that drives the FIR core's sample/coefficient interface and drains its results. Buffers an upstream FP16 sample stream and issues exactly one sample per FIR frame slot. Bulk-loads 64 coefficients from a shadow bank into the core between frames. Captures each FIR output into a small FIFO for a downstream ready/valid consumer. Sits between the system bus/stream fabric and the FIR core, clocked on the fast clock.

Parameters:
FRAME_CYCLES, 256, fast-clock cycles per FIR frame (sample issue period); must be >= 2
IN_DEPTH, 4, input sample FIFO depth (power of 2)
OUT_DEPTH, 4, output result FIFO depth (power of 2)

Ports:
clk_fast  in  1  fast clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request
s_data  in  16  upstream FP16 sample
s_valid  in  1  upstream sample valid
s_ready  out  1  input FIFO not full
cfg_we  in  1  shadow coefficient write strobe
cfg_addr  in  6  shadow write address
cfg_wdata  in  17  shadow write data
cfg_commit  in  1  pulse: push shadow bank to FIR core
cfg_busy  out  1  commit pending or load in progress
fir_din  out  16  sample to FIR core
fir_valid_in  out  1  one-cycle sample strobe
fir_cin  out  17  coefficient to FIR core
fir_caddr  out  6  coefficient address
fir_cload  out  1  coefficient write strobe
fir_dout  in  16  FIR result
fir_valid  in  1  FIR result valid (level)
m_data  out  16  result FIFO head
m_valid  out  1  result FIFO not empty
m_ready  in  1  downstream accept
clr_flags  in  1  clear sticky flags
underrun  out  1  sticky: frame slot with empty input FIFO
overflow  out  1  sticky: result dropped, output FIFO full

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_fast. All outputs 0, FIFOs empty, frame counter 0, state IDLE. s_ready = 1 on the first edge after reset release.
- Input FIFO: push on s_valid & s_ready; s_ready = !full. Push into a full FIFO never occurs.
- State IDLE: no fir_valid_in, no fir_cload. enable=1 -> RUN with frame counter 0. cfg_commit -> LOAD.
- State RUN: frame counter counts 0..FRAME_CYCLES-1 and wraps.
  - Count 0, FIFO non-empty: pop head, register to fir_din, fir_valid_in=1 for the following single cycle.
  - Count 0, FIFO empty: fir_din=16'h0000, fir_valid_in=1, underrun set.
  - Latency from s handshake into an empty FIFO to fir_valid_in is 1 cycle after the next count 0, minimum 2 cycles.
  - fir_din holds its value until the next issue.
- Commit: cfg_commit latches a pending flag; cfg_busy=1 from the next cycle.
  - In RUN, LOAD is entered only after count FRAME_CYCLES-1, never mid-frame.
  - enable=0 in RUN: finish the current frame, then IDLE; a pending commit takes priority, giving LOAD then IDLE.
- State LOAD: 64 cycles, i=0..63.
  - fir_cload=1, fir_caddr=i, fir_cin=shadow[i], all registered.
  - No sample is issued during LOAD; input FIFO still accepts.
  - Exit: RUN (counter 0) if enable, else IDLE. cfg_busy drops the cycle after the last cload.
- Commit during LOAD is ignored, with no re-queue.
- Shadow bank: 64x17. cfg_we writes when cfg_busy=0; cfg_we while busy is ignored.
- Output capture: fir_valid is registered; its rising edge pushes fir_dout sampled on the same edge.
  - Output FIFO full with no same-cycle pop: drop the result, set overflow.
  - Full with a same-cycle pop: push accepted.
- m_valid = !empty, m_data = head, pop on m_valid & m_ready. First-word latency is 2 cycles after fir_valid rises.
- Sticky flags: cleared by clr_flags. A set in the same cycle as clr_flags wins.
- Reset mid-LOAD or mid-frame: immediate return to reset state. A partially loaded core is not repaired; software recommits.

Test Plan:
- Reset, enable=1, push 16'h3C00 then 16'h4000 -> fir_valid_in pulses at counts 0 of frames 1 and 2 with those values, exactly FRAME_CYCLES apart.
- Enable with FIFO empty -> fir_din=0000, fir_valid_in pulse, underrun=1; clr_flags -> 0; clr_flags coinciding with a new underrun -> underrun stays 1.
- Write shadow[i]=i+17'h100 for all i, commit mid-frame -> no cload until frame end, then 64 consecutive cloads with caddr 0..63, cin 100..13F, cfg_busy high throughout, RUN resumes at count 0.
- cfg_we to addr 5 during busy -> shadow[5] unchanged on the next commit; cfg_commit during LOAD -> exactly 64 cloads total.
- m_ready=0, 5 fir_valid rising edges (dout 1..5) with OUT_DEPTH=4 -> FIFO holds 1..4, overflow=1; m_ready=1 -> 1,2,3,4 delivered in order.
- Assert rst_n low at LOAD i=30 -> all outputs 0 immediately, state IDLE, FIFOs empty.

Source files
------------

// File: rtl/fir_host_seq_if.sv
// Host <-> FIR core sample/coefficient/result bundle.
interface fir_host_seq_if;
  logic [15:0] fir_din;
  logic        fir_valid_in;
  logic [16:0] fir_cin;
  logic [5:0]  fir_caddr;
  logic        fir_cload;
  logic [15:0] fir_dout;
  logic        fir_valid;

  modport master (
    output fir_din,
    output fir_valid_in,
    output fir_cin,
    output fir_caddr,
    output fir_cload,
    input  fir_dout,
    input  fir_valid
  );

  modport slave (
    input  fir_din,
    input  fir_valid_in,
    input  fir_cin,
    input  fir_caddr,
    input  fir_cload,
    output fir_dout,
    output fir_valid
  );
endinterface

// File: rtl/fir_host_seq.sv
// Host-side FIR sequencer: issues one buffered sample per frame slot, bulk-loads the
// 64-entry shadow coefficient bank between frames, and queues FIR results downstream.
module fir_host_seq #(
  parameter int unsigned FRAME_CYCLES = 256,
  parameter int unsigned IN_DEPTH     = 4,
  parameter int unsigned OUT_DEPTH    = 4
) (
  input  logic           clk_fast,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [15:0]    s_data,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic           cfg_we,
  input  logic [5:0]     cfg_addr,
  input  logic [16:0]    cfg_wdata,
  input  logic           cfg_commit,
  output logic           cfg_busy,
  fir_host_seq_if.master fir,
  output logic [15:0]    m_data,
  output logic           m_valid,
  input  logic           m_ready,
  input  logic           clr_flags,
  output logic           underrun,
  output logic           overflow
);
  localparam int unsigned CntW  = $clog2(FRAME_CYCLES);
  localparam int unsigned InPw  = $clog2(IN_DEPTH);
  localparam int unsigned InCw  = InPw + 1;
  localparam int unsigned OutPw = $clog2(OUT_DEPTH);
  localparam int unsigned OutCw = OutPw + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StLoad = 2'd2;

  // ---------------- input sample FIFO ----------------
  logic [15:0]     in_mem_q [IN_DEPTH];
  logic [InPw-1:0] in_wr_q, in_rd_q;
  logic [InCw-1:0] in_cnt_q, in_cnt_d;
  logic            s_ready_q, in_push, in_pop, in_empty;

  assign in_empty = (in_cnt_q == '0);
  assign in_push  = s_valid & s_ready_q;
  assign s_ready  = s_ready_q;
  assign in_cnt_d = in_cnt_q + InCw'(in_push) - InCw'(in_pop);

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (in_push) in_wr_q <= in_wr_q + InPw'(1);
      if (in_pop)  in_rd_q <= in_rd_q + InPw'(1);
      in_cnt_q  <= in_cnt_d;
      s_ready_q <= (in_cnt_d != InCw'(IN_DEPTH));
    end
  end

  always_ff @(posedge clk_fast) begin
    if (in_push) in_mem_q[in_wr_q] <= s_data;
  end

  // ---------------- shadow coefficient bank ----------------
  logic [16:0] shadow_q [64];

  always_ff @(posedge clk_fast) begin
    if (cfg_we && !cfg_busy) shadow_q[cfg_addr] <= cfg_wdata;
  end

  // ---------------- sequencer ----------------
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            issue, underrun_set;

  logic [15:0] din_q;
  logic        vin_q, cload_q;
  logic [5:0]  caddr_q;
  logic [16:0] cin_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    issue        = 1'b0;
    in_pop       = 1'b0;
    underrun_set = 1'b0;
    // A commit arriving while the load runs is dropped, not queued.
    if (cfg_commit && (state_q != StLoad)) pending_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (cfg_commit || pending_q) begin
          state_d   = StLoad;
          idx_d     = '0;
          pending_d = 1'b0;
        end else if (enable) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          issue        = 1'b1;
          in_pop       = !in_empty;
          underrun_set = in_empty;
        end
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (pending_q || cfg_commit) begin
            state_d   = StLoad;
            idx_d     = '0;
            pending_d = 1'b0;
          end else if (!enable) begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLoad: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          state_d = enable ? StRun : StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      din_q     <= '0;
      vin_q     <= 1'b0;
      cload_q   <= 1'b0;
      caddr_q   <= '0;
      cin_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      vin_q     <= issue;
      if (issue) din_q <= in_empty ? 16'h0000 : in_mem_q[in_rd_q];
      cload_q   <= (state_q == StLoad);
      if (state_q == StLoad) begin
        caddr_q <= idx_q;
        cin_q   <= shadow_q[idx_q];
      end
    end
  end

  // Busy covers the registered cload tail so it drops the cycle after the last write.
  assign cfg_busy         = pending_q | (state_q == StLoad) | cload_q;
  assign fir.fir_din      = din_q;
  assign fir.fir_valid_in = vin_q;
  assign fir.fir_cload    = cload_q;
  assign fir.fir_caddr    = caddr_q;
  assign fir.fir_cin      = cin_q;

  // ---------------- result capture FIFO ----------------
  logic [15:0]      out_mem_q [OUT_DEPTH];
  logic [OutPw-1:0] out_wr_q, out_rd_q;
  logic [OutCw-1:0] out_cnt_q;
  logic             fv_q, fv_qq, out_rise, out_full, out_push, out_pop, overflow_set;
  logic [15:0]      dout_q;

  assign out_rise     = fv_q & ~fv_qq;
  assign out_full     = (out_cnt_q == OutCw'(OUT_DEPTH));
  assign out_pop      = m_valid & m_ready;
  assign out_push     = out_rise & (~out_full | out_pop);
  assign overflow_set = out_rise & out_full & ~out_pop;
  assign m_valid      = (out_cnt_q != '0);
  assign m_data       = out_mem_q[out_rd_q];

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      fv_q      <= 1'b0;
      fv_qq     <= 1'b0;
      dout_q    <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      fv_q      <= fir.fir_valid;
      fv_qq     <= fv_q;
      dout_q    <= fir.fir_dout;
      if (out_push) out_wr_q <= out_wr_q + OutPw'(1);
      if (out_pop)  out_rd_q <= out_rd_q + OutPw'(1);
      out_cnt_q <= out_cnt_q + OutCw'(out_push) - OutCw'(out_pop);
    end
  end

  always_ff @(posedge clk_fast) begin
    if (out_push) out_mem_q[out_wr_q] <= dout_q;
  end

  // ---------------- sticky flags (set beats clear) ----------------
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (underrun_set)   underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
      if (overflow_set)   overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end
endmodule
